// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction fetch unit.
//   INST_W   : width of one instruction word.
//   PC_INC   : byte step between consecutive sequential fetches.
//   PC_MAX_W : widest PC an entry can carry. XLEN must not exceed it, and
//              narrower PCs sit zero-extended in the low bits.
//   fetch_entry_t : one fetch-buffer slot {pc, inst, filled}.
package fetch_pkg;

    localparam int INST_W   = 32;
    localparam int PC_INC   = 4;
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INST_W-1:0]   inst;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: in-order fetch buffer with three pointers.
//   wr_ptr   - next slot allocated when a request is accepted.
//   fill_ptr - oldest slot still waiting for its instruction word.
//   rd_ptr   - head slot, which is presented to decode.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   flush            drop every entry; the buffer is empty next cycle
//   alloc_en/pc      allocate one entry holding the given PC
//   fill_en/inst     write the instruction into the oldest unfilled entry
//   release_en       pop the head entry. It is ignored unless head_valid.
//   head_valid/inst/pc   head entry, valid once it has been filled
//   alloc_cnt        number of allocated entries
//   unfilled_cnt     number of allocated entries still awaiting data
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic              fill_en,
    input  logic [INST_W-1:0] fill_inst,
    input  logic              release_en,
    output logic              head_valid,
    output logic [INST_W-1:0] head_inst,
    output logic [XLEN-1:0]   head_pc,
    output logic [CW-1:0]     alloc_cnt,
    output logic [CW-1:0]     unfilled_cnt
);

    fetch_entry_t        ent [QDEPTH];
    logic [PW-1:0]       wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]       cnt, ucnt;
    logic                do_alloc, do_fill, do_rel;
    logic [PC_MAX_W-1:0] alloc_pc_ext;

    always_comb begin
        alloc_pc_ext             = '0;
        alloc_pc_ext[XLEN-1:0]   = alloc_pc;
    end

    // The guards keep the pointers consistent even if a caller misbehaves.
    // Such misbehaviour is a full-buffer alloc, a fill with nothing
    // outstanding, or a release of an unfilled head.
    assign do_alloc   = alloc_en && (cnt != CW'(QDEPTH));
    assign do_fill    = fill_en && (ucnt != '0);
    assign head_valid = (cnt != '0) && ent[rd_ptr].filled;
    assign do_rel     = release_en && head_valid;

    assign head_inst    = ent[rd_ptr].inst;
    assign head_pc      = ent[rd_ptr].pc[XLEN-1:0];
    assign alloc_cnt    = cnt;
    assign unfilled_cnt = ucnt;

    // Responses and releases are both in order. For this reason the alloc,
    // fill and release slots in one cycle are always distinct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) ent[i] <= '0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ucnt     <= '0;
        end else if (flush) begin
            for (int i = 0; i < QDEPTH; i++) ent[i].filled <= 1'b0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ucnt     <= '0;
        end else begin
            if (do_rel) begin
                ent[rd_ptr].filled <= 1'b0;
                rd_ptr             <= rd_ptr + 1'b1;
            end
            if (do_alloc) begin
                ent[wr_ptr].pc     <= alloc_pc_ext;
                ent[wr_ptr].inst   <= '0;
                ent[wr_ptr].filled <= 1'b0;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (do_fill) begin
                ent[fill_ptr].inst   <= fill_inst;
                ent[fill_ptr].filled <= 1'b1;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            cnt  <= cnt + CW'(do_alloc) - CW'(do_rel);
            ucnt <= ucnt + CW'(do_alloc) - CW'(do_fill);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect support.
// The unit issues word-aligned requests to instruction memory and buffers
// the returned words in program order. It hands them to decode one per
// handshake. A redirect flushes the buffer and restarts fetch at the
// target. Responses still owed for the flushed requests are counted in
// drop_q and discarded on arrival.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order response, no backpressure
//   redirect_valid/pc               taken branch/jump: flush and refetch
//   inst_valid/ready                decode handshake for the head entry
//   inst_data, inst_pc, inst_pc4    head instruction, its PC and PC+4
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               QDEPTH   = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic [XLEN-1:0]   inst_pc4
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   drop_q;
    logic            run_q;
    logic [CW-1:0]   alloc_cnt, unfilled_cnt;
    logic            req_fire, fill_en, rsp_drop, release_en;
    logic [CW:0]     occupancy, drop_pend, drop_red;
    logic [CW-1:0]   drop_nxt;

    // Slots owed to stale responses count against capacity. In-flight
    // tracking therefore never exceeds QDEPTH, so drop_q cannot overflow.
    assign occupancy      = {1'b0, alloc_cnt} + {1'b0, drop_q};
    assign imem_req_valid = run_q && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (drop_q != '0);
    assign fill_en    = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign release_en = inst_valid && inst_ready;

    // On redirect, every unfilled entry becomes a response to throw away. A
    // response in the redirect cycle is discarded here, so it retires one
    // owed response. That response is either an already stale one or the
    // oldest unfilled entry, so the count is the same in both cases.
    always_comb begin
        drop_pend = {1'b0, drop_q} + {1'b0, unfilled_cnt};
        drop_red  = '0;
        if (drop_pend != '0) drop_red = drop_pend - (CW+1)'(imem_rsp_valid);
        drop_nxt  = drop_red[CW-1:0];
        if (drop_red > (CW+1)'(QDEPTH)) drop_nxt = CW'(QDEPTH);
    end

    // run_q keeps requests off while reset is asserted. It also keeps them
    // off until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= {RESET_PC[XLEN-1:2], 2'b00};
            drop_q <= '0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                pc_q   <= {redirect_pc[XLEN-1:2], 2'b00};
                drop_q <= drop_nxt;
            end else begin
                if (req_fire) pc_q <= pc_q + XLEN'(PC_INC);
                if (rsp_drop) drop_q <= drop_q - 1'b1;
            end
        end
    end

    fetch_buf #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (redirect_valid),
        .alloc_en     (req_fire),
        .alloc_pc     (pc_q),
        .fill_en      (fill_en),
        .fill_inst    (imem_rsp_data),
        .release_en   (release_en),
        .head_valid   (inst_valid),
        .head_inst    (inst_data),
        .head_pc      (inst_pc),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    assign inst_pc4 = inst_pc + XLEN'(PC_INC);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req_valid, imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_valid, inst_ready;
    logic [31:0]       inst_data;
    logic [XLEN-1:0]   inst_pc, inst_pc4;

    fetch_unit #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0, cyc = 0;

    // Reference model: a memory with per-request latency. Each request is
    // tagged with the redirect epoch it was issued in. The model counts
    // the current epoch's requests, responses and deliveries.
    typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
    mreq_t       mq[$];
    bit          run;
    int          ep, iss, rsp, del, lat;
    logic [31:0] exp_req_pc, exp_del_pc;
    logic [31:0] req_log[$], del_pc_log[$], del_pc4_log[$];
    int          act_req_cnt;
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_pc4, s_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        run = 0; ep++; iss = 0; rsp = 0; del = 0;
        exp_req_pc = 32'h0; exp_del_pc = 32'h0;
    endtask

    // One clock cycle. The task drives the memory response, samples at the
    // negedge, checks the outputs against the model, then advances the model.
    task automatic step();
        bit          erv, eiv;
        int          stale;
        logic [31:0] e_data, e_pc4;
        mreq_t       m;
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h2000_0000 + mq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        stale = 0;
        foreach (mq[i]) if (mq[i].ep != ep) stale++;
        if (!rst_n) begin
            erv = 0; eiv = 0;
        end else begin
            erv = run && !redirect_valid && ((iss - del) + stale < QDEPTH);
            eiv = (rsp > del);
        end
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid;
        s_pc = inst_pc; s_pc4 = inst_pc4; s_data = inst_data;
        chk("req_valid", s_rv, erv);
        if (erv) chk("req_addr", s_addr, exp_req_pc);
        chk("inst_valid", s_iv, eiv);
        if (eiv) begin
            e_data = 32'h2000_0000 + exp_del_pc;
            e_pc4  = exp_del_pc + 32'd4;
            chk("inst_pc", s_pc, exp_del_pc);
            chk("inst_data", s_data, e_data);
            chk("inst_pc4", s_pc4, e_pc4);
        end
        if (s_rv && imem_req_ready) act_req_cnt++;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (imem_rsp_valid) begin
                if (mq[0].ep == ep) rsp++;
                void'(mq.pop_front());
            end
            if (eiv && inst_ready) begin
                del++;
                del_pc_log.push_back(s_pc);
                del_pc4_log.push_back(s_pc4);
                exp_del_pc += 32'd4;
            end
            if (erv && imem_req_ready) begin
                m.addr = exp_req_pc; m.due = cyc + lat; m.ep = ep;
                mq.push_back(m);
                req_log.push_back(s_addr);
                iss++;
                exp_req_pc += 32'd4;
            end
            if (redirect_valid) begin
                ep++; iss = 0; rsp = 0; del = 0;
                exp_req_pc = {redirect_pc[31:2], 2'b00};
                exp_del_pc = exp_req_pc;
            end
            run = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rst_req_valid", s_rv, 0);
        chk("rst_inst_valid", s_iv, 0);
        step();
        rst_n = 1'b1;
        act_req_cnt = 0;
        req_log.delete(); del_pc_log.delete(); del_pc4_log.delete();
    endtask

    task automatic wait_del(input int n, input int budget, input string nm);
        int k = 0;
        while (del_pc_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (del_pc_log.size() < n) begin
            nchk++; nerr++;
            $display("FAIL %s: timeout, got %0d deliveries expected %0d", nm, del_pc_log.size(), n);
        end
    endtask

    typedef struct {
        bit rst; bit rdy; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t v(bit rst, bit rdy, bit rv, logic [31:0] a, bit iv, logic [31:0] p);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rv = rv; t.addr = a; t.iv = iv; t.pc = p;
        return t;
    endfunction

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1; lat = 1;
        model_reset();

        // Zero-wait stream from reset, then decode stalled for 10+ cycles.
        tbl[0]  = v(1, 1, 0, 0,  0, 0);
        tbl[1]  = v(0, 1, 1, 0,  0, 0);
        tbl[2]  = v(0, 1, 1, 4,  0, 0);
        tbl[3]  = v(0, 1, 1, 8,  1, 0);
        tbl[4]  = v(0, 1, 1, 12, 1, 4);
        tbl[5]  = v(0, 1, 1, 16, 1, 8);
        tbl[6]  = v(0, 1, 1, 20, 1, 12);
        tbl[7]  = v(1, 0, 0, 0,  0, 0);
        tbl[8]  = v(0, 0, 1, 0,  0, 0);
        tbl[9]  = v(0, 0, 1, 4,  0, 0);
        tbl[10] = v(0, 0, 1, 8,  1, 0);
        tbl[11] = v(0, 0, 1, 12, 1, 0);
        for (int i = 12; i < 18; i++) tbl[i] = v(0, 0, 0, 0, 1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            logic [31:0] p4;
            if (tbl[i].rst) do_reset();
            inst_ready = tbl[i].rdy; imem_req_ready = 1'b1; lat = 1;
            step();
            chk("tbl_req_valid", s_rv, tbl[i].rv);
            if (tbl[i].rv) chk("tbl_req_addr", s_addr, tbl[i].addr);
            chk("tbl_inst_valid", s_iv, tbl[i].iv);
            if (tbl[i].iv) begin
                p4 = tbl[i].pc + 32'd4;
                chk("tbl_inst_pc", s_pc, tbl[i].pc);
                chk("tbl_inst_pc4", s_pc4, p4);
            end
        end
        chk("stall_req_count", act_req_cnt, 4);

        // Redirect with three requests in flight at latency 5.
        do_reset(); lat = 5; inst_ready = 1'b1;
        repeat (4) step();
        chk("r1_inflight", act_req_cnt, 3);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        step();
        chk("r1_req_valid", s_rv, 1);
        chk("r1_req_addr", s_addr, 32'h100);
        wait_del(1, 40, "r1_deliver");
        if (del_pc_log.size() >= 1) chk("r1_first_pc", del_pc_log[0], 32'h100);

        // Redirect together with a response and a decode handshake.
        do_reset(); lat = 2; inst_ready = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        chk("r2_hs_once", del_pc_log.size(), 1);
        if (del_pc_log.size() >= 1) chk("r2_hs_pc", del_pc_log[0], 32'h0);
        wait_del(2, 40, "r2_deliver");
        if (del_pc_log.size() >= 2) chk("r2_next_pc", del_pc_log[1], 32'h400);

        // Two redirects one cycle apart.
        do_reset(); lat = 4; inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        step();
        chk("r3_req_addr", s_addr, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        wait_del(2, 60, "r3_deliver");
        if (del_pc_log.size() >= 2) begin
            chk("r3_first_pc", del_pc_log[0], 32'h300);
            chk("r3_second_pc", del_pc_log[1], 32'h304);
        end

        // PC wrap at the top of the address space.
        do_reset(); lat = 1; inst_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        req_log.delete(); del_pc_log.delete(); del_pc4_log.delete();
        wait_del(3, 40, "wrap_deliver");
        if (req_log.size() >= 3 && del_pc_log.size() >= 3) begin
            chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", req_log[2], 32'h0000_0000);
            chk("wrap_pc", del_pc_log[2], 32'h0000_0000);
            chk("wrap_pc4", del_pc4_log[2], 32'h0000_0004);
        end

        // Random traffic with stalls, redirects, and a reset mid-operation.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            inst_ready     = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            step();
            redirect_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
